// File: rtl/ram_fifo_stream_pkg.sv
// Shared constants for the RAM-backed streaming FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ram_fifo_stream_pkg;

  // Edges from raddr presentation to data at the RAM output register.
  localparam int RAM_RD_LAT = 3;
  localparam int DEF_WIDTH  = 18;
  localparam int DEF_AW     = 10;

endpackage

// File: rtl/obuf_fifo.sv
// Small register FIFO that holds words returned from the RAM until consumed.
// Latency: a write is visible at rd_data on the next cycle; reads are fall-through from the head.
// Backpressure: none internally; the writer must guarantee space (no overflow check).
//
// Ports: clk, rst; wr_en/wr_data push; rd_en pop; rd_data head word; vld non-empty; cnt occupancy.
module obuf_fifo #(
  parameter int  WIDTH = 18,
  parameter int  DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             vld,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) wptr <= ptr_inc(wptr);
      if (rd_en) rptr <= ptr_inc(rptr);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem[rptr];
  assign vld     = (cnt != '0);

endmodule

// File: rtl/ram_2port_pipe.sv
// Simple dual-port RAM, one write port and one pipelined read port.
// Latency: 3 edges from raddr to rdata (address reg, array read, output reg).
// Backpressure: none; the read pipeline runs every cycle, validity is tracked by the caller.
//
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata read data.
// Contents are deliberately not reset.
module ram_2port_pipe #(
  parameter int WIDTH = 18,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]    raddr_q;
  logic [WIDTH-1:0] array_q;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    raddr_q <= raddr;
    array_q <= mem[raddr_q];
    rdata_q <= array_q;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_fifo_stream.sv
// Deep streaming FIFO: words stored in a pipelined RAM, prefetched into a small output buffer.
// Latency: 4 edges from accepting edge to out_valid on an empty FIFO; 1 word/clock sustained.
// Backpressure: in_ready = not full (registered); reads are issued only when the buffer has room.
//
// Ports: clk, rst (sync, active high); in_valid/in_data/in_ready upstream;
//        out_valid/out_data/out_ready downstream; count total words held; full, empty flags.
module ram_fifo_stream
  import ram_fifo_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW,
  parameter int OBUF  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam int          OCW   = $clog2(OBUF + 1);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  // Pointers carry one extra bit so that wr_ptr - rd_ptr can express 2**AW unread words.
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           unread;
  logic [AW:0]           count_nxt;
  logic [RAM_RD_LAT-1:0] rd_vld_pipe;
  logic [WIDTH-1:0]      ram_rdata;
  logic [OCW-1:0]        obuf_cnt;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  int                    occ;

  // Gated by rst so nothing is accepted during reset; full is registered, so no
  // combinational path exists from out_ready.
  assign in_ready = ~rst & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign unread   = wr_ptr - rd_ptr;

  // Buffer slots committed = reads in flight + buffered words. A pop on this edge frees
  // a slot long before a read issued now can land (RAM_RD_LAT+1 edges later), so it is
  // credited; without that, a full pipeline with one buffered word would stall every
  // fourth cycle instead of streaming one word per clock.
  always_comb begin
    occ      = $countones(rd_vld_pipe) + int'(obuf_cnt) - int'(pop);
    rd_issue = (unread != '0) && (occ < OBUF);
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_vld_pipe <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      rd_vld_pipe <= {rd_vld_pipe[RAM_RD_LAT-2:0], rd_issue};
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH);
      empty       <= (count_nxt == '0);
    end
  end

  ram_2port_pipe #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  // The last valid stage marks ram_rdata as a real word; it is captured on the next edge.
  obuf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (OBUF)
  ) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rd_vld_pipe[RAM_RD_LAT-1]),
    .wr_data (ram_rdata),
    .rd_en   (pop),
    .rd_data (out_data),
    .vld     (out_valid),
    .cnt     (obuf_cnt)
  );

endmodule

// File: tb/tb_ram_fifo_stream.sv
module tb_ram_fifo_stream;

  localparam int WIDTH = 18;
  localparam int AW    = 10;
  localparam int OBUF  = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  always #5 clk = ~clk;

  ram_fifo_stream #(
    .WIDTH (WIDTH),
    .AW    (AW),
    .OBUF  (OBUF)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: words accepted upstream must leave in the same order, count must equal
  // the number of words held, a stalled head must not change, and the output buffer
  // must stay within its depth.
  logic [WIDTH-1:0] q[$];
  logic             hold_vld = 1'b0;
  logic [WIDTH-1:0] hold_dat = '0;
  logic [WIDTH-1:0] exp_w;
  logic [WIDTH-1:0] last_pop = '0;
  int               pops = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_vld = 1'b0;
    end else begin
      check("count_vs_model", 32'(count), 32'(q.size()));
      check("obuf_bound", 32'(u_dut.u_obuf.cnt <= OBUF), 1);
      if (hold_vld && out_valid) check("stall_stable", 32'(out_data), 32'(hold_dat));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_pop", 32'(out_valid), 0);
        end else begin
          exp_w = q.pop_front();
          check("order", 32'(out_data), 32'(exp_w));
          last_pop = out_data;
          pops++;
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      hold_vld = out_valid && !out_ready;
      hold_dat = out_data;
    end
  end

  int ok;

  initial begin
    // Reset state
    repeat (3) tick;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_count", 32'(count), 0);
    rst = 1'b0;
    #1;
    check("release_in_ready", 32'(in_ready), 1);

    // Single word, first-word latency of 4 edges
    in_valid = 1'b1; in_data = 18'h00001; out_ready = 1'b1;
    tick;                      // E0
    in_valid = 1'b0;
    check("one_count_e0", 32'(count), 1);
    check("one_valid_e0", 32'(out_valid), 0);
    tick; tick; tick;          // E3
    check("one_valid_e3", 32'(out_valid), 0);
    tick;                      // E4
    check("one_valid_e4", 32'(out_valid), 1);
    check("one_data_e4", 32'(out_data), 32'h1);
    check("one_count_e4", 32'(count), 1);
    tick;                      // pop
    check("one_count_pop", 32'(count), 0);
    check("one_empty_pop", 32'(empty), 1);
    check("one_valid_pop", 32'(out_valid), 0);

    // Fill to 1024 with the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      tick;
    end
    in_valid = 1'b0;
    check("fill_full", 32'(full), 1);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_count", 32'(count), 1024);
    check("fill_empty", 32'(empty), 0);
    check("fill_head", 32'(out_data), 0);
    in_valid = 1'b1; in_data = 18'h3FFFF;
    tick;
    in_valid = 1'b0;
    check("push1025_count", 32'(count), 1024);
    check("push1025_full", 32'(full), 1);

    // Push and pop together at full: push rejected, pop proceeds
    in_valid = 1'b1; in_data = 18'h2AAAA; out_ready = 1'b1;
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    check("fullpp_count", 32'(count), 1023);
    check("fullpp_full", 32'(full), 0);
    check("fullpp_in_ready", 32'(in_ready), 1);
    check("fullpp_head", 32'(out_data), 1);

    // Drain the rest
    pops = 0;
    out_ready = 1'b1;
    for (int g = 0; g < 2000 && !empty; g++) tick;
    check("drain_empty", 32'(empty), 1);
    check("drain_pops", 32'(pops), 1023);
    check("drain_last", 32'(last_pop), 1023);
    check("drain_count", 32'(count), 0);

    // Continuous stream of 3000 words, pointers wrap twice
    ok = 0;
    for (int k = 0; k <= 3004; k++) begin
      in_valid = (k < 3000);
      in_data  = WIDTH'(32'h10000 + k);
      tick;
      if (k == 3) check("stream_latency", 32'(out_valid), 0);
      if (k >= 4 && k < 3004 && out_valid && out_data == WIDTH'(32'h10000 + k - 4)) ok++;
      if (k == 3004) check("stream_tail_idle", 32'(out_valid), 0);
    end
    check("stream_one_per_clock", 32'(ok), 3000);

    // Random valid/ready
    for (int k = 0; k < 2000; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = WIDTH'($urandom);
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int g = 0; g < 2000 && !empty; g++) tick;
    check("random_drained", 32'(empty), 1);

    // Reset with reads in flight and a buffered word
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(32'h100 + k);
      tick;
    end
    check("pre_rst_valid", 32'(out_valid), 1);
    check("pre_rst_inflight", 32'($countones(u_dut.rd_vld_pipe)), 3);
    rst = 1'b1; in_valid = 1'b0;
    tick;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 18'h2BCDE;   // 0xABCDE truncated to 18 bits
    tick;                                   // E0
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick;
      check("post_rst_no_stale", 32'(out_valid), 0);
    end
    tick;                                   // E4
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_data", 32'(out_data), 32'h2BCDE);
    repeat (6) tick;
    check("post_rst_empty", 32'(empty), 1);
    check("post_rst_idle", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_stream.md
RAM_FIFO_STREAM -- requirements
Module: ram_fifo_stream

Interface
REQ-001 Parameter WIDTH, default 18, data word width; SHALL match the ram_2port_pipe data width.
REQ-002 Parameter AW, default 10, address width; FIFO depth SHALL be 2**AW = 1024 words.
REQ-003 Parameter OBUF, default 4, output buffer entries; SHALL be at least RAM read latency + 1.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  WIDTH  head-of-FIFO word.
REQ-011 out_ready  input  1  downstream consumes this cycle.
REQ-012 count  output  AW+1  total words held: RAM plus in-flight reads plus output buffer.
REQ-013 full, empty  output  1 each  registered status flags.

Function
REQ-014 Push SHALL occur on an edge where in_valid and in_ready are both high; pop SHALL occur on an edge where out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal not full; it SHALL NOT depend combinationally on out_ready.
REQ-016 A push SHALL write in_data to RAM address wr_ptr and increment wr_ptr modulo 2**AW.
REQ-017 A read SHALL issue when the RAM holds at least one unread word and (reads in flight + output-buffer entries) < OBUF; an issue SHALL present rd_ptr as raddr and increment rd_ptr modulo 2**AW.
REQ-018 RAM read latency SHALL be 3 edges (address register, array read, output register); a 3-stage valid shift register SHALL track in-flight reads.
REQ-019 A returning word SHALL be written into the output buffer on the edge after its valid stage 3 is set; the buffer SHALL never overflow, guaranteed by REQ-017.
REQ-020 out_data SHALL be the output-buffer head; out_valid SHALL be high whenever the buffer is non-empty.
REQ-021 First-word latency into an empty block SHALL be 4 edges; out_valid rises after edge E0+4, where E0 is the accepting edge.
REQ-022 With out_ready held high and a continuous input stream, throughput SHALL be one word per clock.
REQ-023 count SHALL increment on push only, decrement on pop only, and remain unchanged on simultaneous push and pop.
REQ-024 full SHALL be high when count == 2**AW; empty SHALL be high when count == 0.
REQ-025 Simultaneous push and pop at full SHALL reject the push, because in_ready is low; the pop proceeds.
REQ-026 Pointer wrap from 1023 to 0 SHALL be seamless, with no loss or duplication of words.
REQ-027 Words SHALL leave in strict arrival order; out_data SHALL be held stable while out_valid is high and out_ready is low.

Reset
REQ-028 While rst is high, on each edge: wr_ptr, rd_ptr and count SHALL clear to 0, the valid pipe and output buffer SHALL clear, out_valid=0, full=0, empty=1, and in_ready=0.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset mid-operation SHALL discard all in-flight reads; stale RAM output SHALL never appear at out_data.
REQ-031 RAM contents SHALL NOT be reset.

Structure
REQ-032 A shared package SHALL hold the constants RAM_RD_LAT=3, default WIDTH and default AW.
REQ-033 The block SHALL instantiate one ram_2port_pipe as its storage sub-module.
REQ-034 The output buffer SHALL be a separate small sub-module, obuf_fifo, of depth OBUF.

Verification
REQ-035 Reset, then push 0x00001 at E0 with out_ready=1 -> out_valid=1 and out_data=0x00001 after E4, with count 1 -> 0 on the pop.
REQ-036 Push 1024 words 0..1023 with out_ready=0 -> full=1 and in_ready=0 after the last push; a 1025th push is ignored; drain -> 0..1023 in order, then empty=1.
REQ-037 Continuous stream of 3000 incrementing words with out_ready=1 -> one output per clock after the initial 4-cycle latency; pointers wrap twice; no gaps or errors.
REQ-038 Random out_ready (50%) with random in_valid -> out_data stable while stalled, in-order data, output buffer never exceeds 4 entries.
REQ-039 At full, in_valid=1 and out_ready=1 on the same edge -> one pop, push rejected, count goes from 1024 to 1023.
REQ-040 Assert rst with 3 reads in flight and buffer non-empty -> out_valid=0 on the next cycle; push 0xABCDE after reset -> the first output is 0xABCDE.
